alu_rr_scheduler: RTL and testbench

//  Shares one registered ALU (alu_top, 2 register stages) among NREQ requesters.

---
 rtl/alu_pkg.sv | 38 +++
 rtl/alu_top.sv | 83 ++++++++
 rtl/rr_arbiter.sv | 35 +++
 rtl/alu_rr_scheduler.sv | 97 +++++++++
 tb/tb_alu_rr_scheduler.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes, tag type and small helpers for the ALU and its round-robin front end.
package alu_pkg;

  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned FLAG_W   = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned MAX_NREQ = 8;
  localparam int unsigned ID_W     = $clog2(MAX_NREQ);

  // Flag bit positions within the 4-bit flags word
  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7
  } alu_op_e;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } alu_tag_t;

  // Pointer to the requester after id, wrapping at nreq
  function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] id,
                                               input int unsigned nreq);
    return ((32'(id) + 32'd1) >= nreq) ? '0 : id + 1'b1;
  endfunction

endpackage

// File: rtl/alu_top.sv
// Two-stage registered ALU: operands captured on the first edge, result/flags on the second.
module alu_top
  import alu_pkg::*;
#(
  parameter int unsigned N = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N-1:0]        a,
  input  logic [N-1:0]        b,
  input  logic [ALU_OP_W-1:0] op,
  output logic [2*N-1:0]      result,
  output logic [FLAG_W-1:0]   flags
);

  localparam int unsigned RES_W = 2 * N;
  localparam int unsigned SH_W  = $clog2(N);

  logic [N-1:0]        a_q;
  logic [N-1:0]        b_q;
  logic [ALU_OP_W-1:0] op_q;
  logic [N:0]          sum_c;
  logic [N:0]          diff_c;
  logic [RES_W-1:0]    res_c;
  logic                carry_c;
  logic                ovf_c;
  logic                neg_c;

  assign sum_c  = {1'b0, a_q} + {1'b0, b_q};
  assign diff_c = {1'b0, a_q} - {1'b0, b_q};

  // Result select; add/sub report N-bit signed flags, others report on the wide result
  always_comb begin
    res_c   = '0;
    carry_c = 1'b0;
    ovf_c   = 1'b0;
    neg_c   = 1'b0;
    case (op_q)
      OP_ADD: begin
        res_c   = RES_W'(sum_c);
        carry_c = sum_c[N];
        ovf_c   = (a_q[N-1] == b_q[N-1]) && (sum_c[N-1] != a_q[N-1]);
        neg_c   = sum_c[N-1];
      end
      OP_SUB: begin
        res_c   = RES_W'(diff_c[N-1:0]);
        carry_c = diff_c[N];
        ovf_c   = (a_q[N-1] != b_q[N-1]) && (diff_c[N-1] != a_q[N-1]);
        neg_c   = diff_c[N-1];
      end
      OP_MUL: begin
        res_c = RES_W'(a_q) * RES_W'(b_q);
        neg_c = res_c[RES_W-1];
      end
      OP_AND: res_c = RES_W'(a_q & b_q);
      OP_OR:  res_c = RES_W'(a_q | b_q);
      OP_XOR: res_c = RES_W'(a_q ^ b_q);
      OP_SHL: begin
        res_c = RES_W'(a_q) << b_q[SH_W-1:0];
        neg_c = res_c[RES_W-1];
      end
      OP_SHR: res_c = RES_W'(a_q >> b_q[SH_W-1:0]);
      default: res_c = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      result <= '0;
      flags  <= '0;
    end else begin
      a_q    <= a;
      b_q    <= b;
      op_q   <= op;
      result <= res_c;
      flags  <= {(res_c == '0), neg_c, carry_c, ovf_c};
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: lowest requester at or above ptr wins, then wraps.
module rr_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            gnt_any
);

  // Two passes: ptr..NREQ-1 first, then 0..ptr-1
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_any && req[i] && (i >= 32'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_id  = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!gnt_any && req[i] && (i < 32'(ptr))) begin
        gnt[i]  = 1'b1;
        gnt_id  = ID_W'(i);
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Round-robin front end sharing one pipelined ALU among NREQ requesters; a tag pipe
// aligned with the ALU latency steers each result back to the requester that issued it.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned N    = 32,
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*N-1:0]        req_a,
  input  logic [NREQ*N-1:0]        req_b,
  input  logic [NREQ*ALU_OP_W-1:0] req_op,
  output logic [N-1:0]             alu_a,
  output logic [N-1:0]             alu_b,
  output logic [ALU_OP_W-1:0]      alu_op,
  input  logic [2*N-1:0]           alu_result,
  input  logic [FLAG_W-1:0]        alu_flags,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [2*N-1:0]           rsp_result,
  output logic [FLAG_W-1:0]        rsp_flags,
  output logic [CNT_W-1:0]         issue_cnt
);

  logic [ID_W-1:0] ptr;
  logic [NREQ-1:0] req_live;
  logic [NREQ-1:0] gnt;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;
  alu_tag_t        tag_q [LAT];

  // Nothing is granted while reset is held
  assign req_live = reset ? '0 : req_valid;

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .req     (req_live),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign req_ready = gnt;

  // Steer the granted payload onto the ALU; zero when idle
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        alu_a  = req_a[i*N +: N];
        alu_b  = req_b[i*N +: N];
        alu_op = req_op[i*ALU_OP_W +: ALU_OP_W];
      end
    end
  end

  // Pointer, issue counter and tag pipe; reset drops every in-flight tag
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr       <= '0;
      issue_cnt <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      if (gnt_any) begin
        ptr       <= next_ptr(gnt_id, NREQ);
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      tag_q[0] <= '{vld: gnt_any, id: gnt_id};
      for (int unsigned s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  // Last tag stage lines up with the ALU result register
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!reset && tag_q[LAT-1].vld && (tag_q[LAT-1].id == ID_W'(i))) begin
        rsp_valid[i] = 1'b1;
      end
    end
  end

  assign rsp_result = alu_result;
  assign rsp_flags  = alu_flags;

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler driving a real alu_top; responses are checked from a queue.
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int LAT  = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ*N-1:0]   req_a;
  logic [NREQ*N-1:0]   req_b;
  logic [NREQ*4-1:0]   req_op;
  logic [N-1:0]        alu_a;
  logic [N-1:0]        alu_b;
  logic [3:0]          alu_op;
  logic [2*N-1:0]      alu_result;
  logic [3:0]          alu_flags;
  logic [NREQ-1:0]     rsp_valid;
  logic [2*N-1:0]      rsp_result;
  logic [3:0]          rsp_flags;
  logic [15:0]         issue_cnt;

  logic [N-1:0] pa  [NREQ];
  logic [N-1:0] pb  [NREQ];
  alu_op_e      pop [NREQ];

  typedef struct {
    int             rid;
    logic [2*N-1:0] res;
    int             due;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   rem [NREQ];
  int   exp_order[$];
  int   vectors = 0;
  int   errors  = 0;
  int   cyc     = 0;
  logic [NREQ-1:0] prev_valid = '0;
  logic [NREQ-1:0] prev_ready = '0;
  logic            prev_reset = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*N +: N]  = pa[g];
    assign req_b[g*N +: N]  = pb[g];
    assign req_op[g*4 +: 4] = pop[g];
  end

  alu_rr_scheduler #(.N(N), .NREQ(NREQ), .LAT(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .issue_cnt  (issue_cnt)
  );

  alu_top #(.N(N)) u_alu (
    .clk    (clk),
    .reset  (reset),
    .a      (alu_a),
    .b      (alu_b),
    .op     (alu_op),
    .result (alu_result),
    .flags  (alu_flags)
  );

  function automatic logic [2*N-1:0] model(input logic [N-1:0] a, input logic [N-1:0] b,
                                           input alu_op_e op);
    case (op)
      OP_ADD:  return {{N{1'b0}}, a} + {{N{1'b0}}, b};
      OP_SUB:  return {{N{1'b0}}, a - b};
      OP_MUL:  return {{N{1'b0}}, a} * {{N{1'b0}}, b};
      OP_XOR:  return {{N{1'b0}}, a ^ b};
      default: return '0;
    endcase
  endfunction

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample point: request-hold rule and response scoreboard
  task automatic sample();
    @(negedge clk);
    if (!reset && !prev_reset) begin
      vectors++;
      if ((prev_valid & ~prev_ready & ~req_valid) !== '0) begin
        errors++;
        $display("FAIL hold_valid: valid dropped without transfer prev=%b now=%b cyc=%0d",
                 prev_valid, req_valid, cyc);
      end
    end
    prev_valid = req_valid;
    prev_ready = req_ready;
    prev_reset = reset;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      vectors++;
      errors++;
      $display("FAIL rsp_missing: requester %0d got nothing, required rsp at cyc %0d",
               sb[0].rid, sb[0].due);
      void'(sb.pop_front());
    end
    if (rsp_valid !== '0) begin
      vectors++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected: rsp_valid=%b at cyc %0d, required none", rsp_valid, cyc);
      end else begin
        e = sb.pop_front();
        if (rsp_valid !== (NREQ'(1) << e.rid) || rsp_result !== e.res ||
            rsp_flags[FLAG_Z] !== (e.res == '0) || cyc != e.due) begin
          errors++;
          $display("FAIL rsp: valid=%b result=%h zf=%b cyc=%0d, required valid=%b result=%h zf=%b cyc=%0d",
                   rsp_valid, rsp_result, rsp_flags[FLAG_Z], cyc,
                   NREQ'(1) << e.rid, e.res, (e.res == '0), e.due);
        end
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  // Requesters hold valid while rem[i] ops remain; grants must follow exp_order
  task automatic burst(input string name, input bit track);
    int k = 0;
    while (k < exp_order.size()) begin
      for (int i = 0; i < NREQ; i++) req_valid[i] = (rem[i] > 0);
      sample();
      vectors++;
      if (req_ready !== (NREQ'(1) << exp_order[k])) begin
        errors++;
        $display("FAIL %s grant %0d: req_ready=%b, required %b", name, k, req_ready,
                 NREQ'(1) << exp_order[k]);
      end
      if (track)
        sb.push_back('{rid: exp_order[k],
                       res: model(pa[exp_order[k]], pb[exp_order[k]], pop[exp_order[k]]),
                       due: cyc + LAT});
      rem[exp_order[k]]--;
      k++;
      advance();
    end
    req_valid = '0;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    req_valid = '1;
    for (int i = 0; i < 3; i++) begin
      sample();
      vectors++;
      if (req_ready !== '0 || rsp_valid !== '0 || issue_cnt !== 16'd0 || alu_a !== '0) begin
        errors++;
        $display("FAIL reset: ready=%b rsp_valid=%b issue_cnt=%0d alu_a=%h, required all zero",
                 req_ready, rsp_valid, issue_cnt, alu_a);
      end
      advance();
    end
    reset     = 1'b0;
    req_valid = '0;
  endtask

  task automatic test_all_valid();
    rem       = '{2, 2, 2, 2};
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
    burst("all_valid", 1'b1);
    sample();
    vectors++;
    if (issue_cnt !== 16'd8) begin
      errors++;
      $display("FAIL all_valid issue_cnt: got %0d, required 8", issue_cnt);
    end
    advance();
    idle(3);
  endtask

  task automatic test_single();
    pa[2]     = 32'd5;
    pb[2]     = 32'd3;
    pop[2]    = OP_ADD;
    req_valid = 4'b0100;
    sample();
    vectors++;
    if (req_ready !== 4'b0100 || alu_a !== 32'd5 || alu_b !== 32'd3 || alu_op !== 4'(OP_ADD)) begin
      errors++;
      $display("FAIL single issue: ready=%b a=%0d b=%0d op=%0d, required 0100 5 3 0",
               req_ready, alu_a, alu_b, alu_op);
    end
    sb.push_back('{rid: 2, res: 64'd8, due: cyc + LAT});
    advance();
    req_valid = '0;
    idle(3);
    sample();
    vectors++;
    if (issue_cnt !== 16'd9) begin
      errors++;
      $display("FAIL single issue_cnt: got %0d, required 9", issue_cnt);
    end
    advance();
  endtask

  task automatic test_fairness();
    rem       = '{0, 1, 0, 0};
    exp_order = '{1};
    burst("fair_setup", 1'b1);
    rem       = '{0, 2, 0, 2};
    exp_order = '{3, 1, 3, 1};
    burst("fairness", 1'b1);
    idle(3);
  endtask

  task automatic test_reset_midflight();
    rem       = '{1, 1, 0, 0};
    exp_order = '{0, 1};
    burst("midflight_issue", 1'b0);
    reset = 1'b1;
    sample();
    vectors++;
    if (rsp_valid !== '0) begin
      errors++;
      $display("FAIL midflight rsp during reset: rsp_valid=%b, required 0000", rsp_valid);
    end
    advance();
    reset = 1'b0;
    idle(3);
    rem       = '{1, 0, 0, 1};
    exp_order = '{0, 3};
    burst("after_reset", 1'b1);
    idle(3);
  endtask

  task automatic test_counter_wrap();
    reset = 1'b1;
    advance();
    reset     = 1'b0;
    pa[0]     = 32'd10;
    pb[0]     = 32'd4;
    pop[0]    = OP_SUB;
    req_valid = 4'b0001;
    for (int i = 0; i < 65535; i++) begin
      sample();
      vectors++;
      if (req_ready !== 4'b0001) begin
        errors++;
        $display("FAIL wrap preload %0d: req_ready=%b, required 0001", i, req_ready);
      end
      sb.push_back('{rid: 0, res: 64'd6, due: cyc + LAT});
      advance();
    end
    sample();
    vectors++;
    if (issue_cnt !== 16'hFFFF || req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL wrap preload: issue_cnt=%h ready=%b, required ffff 0001", issue_cnt, req_ready);
    end
    sb.push_back('{rid: 0, res: 64'd6, due: cyc + LAT});
    advance();
    req_valid = '0;
    sample();
    vectors++;
    if (issue_cnt !== 16'd0) begin
      errors++;
      $display("FAIL wrap: issue_cnt=%h, required 0000", issue_cnt);
    end
    advance();
    idle(3);
  endtask

  task automatic test_drain();
    idle(4);
    vectors++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    pa  = '{32'h7FFF_FFFF, 32'd3, 32'h1234_5678, 32'hDEAD_BEEF};
    pb  = '{32'd1, 32'd5, 32'h9ABC_DEF0, 32'hDEAD_BEEF};
    pop = '{OP_ADD, OP_SUB, OP_MUL, OP_XOR};
    test_reset();
    test_all_valid();
    test_single();
    pa[1] = 32'hFFFF_FFFF; pb[1] = 32'd1;          pop[1] = OP_ADD;
    pa[3] = 32'hFFFF_FFFF; pb[3] = 32'hFFFF_FFFF;  pop[3] = OP_MUL;
    test_fairness();
    test_reset_midflight();
    test_counter_wrap();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
